// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller: state encoding and threshold defaults.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  // Almost-full defaults to MEM_SIZE minus this margin; almost-empty to a fixed level.
  localparam int TH_AF_MARGIN  = 2;
  localparam int TH_AE_DEFAULT = 2;

  function automatic int th_af_default(input int mem_size);
    return mem_size - TH_AF_MARGIN;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller driving an external memory; strobes are combinational,
// pointers/occupancy update at the accepting edge. Overflow/underflow locks in ERROR until reset.
module fifo_ctrl #(
  parameter int MEM_SIZE = 8,
  parameter int PTR      = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  input  logic [PTR:0]   th_af,
  input  logic [PTR:0]   th_ae,
  input  logic           push_req,
  input  logic           pop_req,
  output logic [PTR-1:0] wr_ptr,
  output logic [PTR-1:0] rd_ptr,
  output logic           mem_push,
  output logic           mem_pop,
  output logic [PTR:0]   occupancy,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic           error,
  output logic           idle
);
  import fifo_pkg::*;

  localparam logic [PTR:0] OCC_MAX   = (PTR+1)'(MEM_SIZE);
  localparam logic [PTR:0] TH_AF_RST = (PTR+1)'(th_af_default(MEM_SIZE));
  localparam logic [PTR:0] TH_AE_RST = (PTR+1)'(TH_AE_DEFAULT);

  state_t       state, state_nxt;
  logic [PTR:0] th_af_reg, th_ae_reg;
  logic [PTR:0] occ_nxt;
  logic         reinit, push_ok, pop_ok, overflow, underflow, violation;

  assign full         = (occupancy == OCC_MAX);
  assign empty        = (occupancy == '0);
  assign almost_full  = (occupancy >= th_af_reg);
  assign almost_empty = (occupancy <= th_ae_reg);

  // An IDLE cycle with init=1 hands control back to INIT, so its requests are dropped.
  always_comb begin
    reinit    = (state == ST_IDLE) && init;
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (reset && !reinit && (state == ST_IDLE || state == ST_ACTIVE)) begin
      push_ok   = push_req && !full;
      pop_ok    = pop_req && !empty && (state == ST_ACTIVE);
      overflow  = push_req && full;
      underflow = pop_req && empty;
    end
  end

  assign violation = overflow || underflow;
  assign occ_nxt   = occupancy + (PTR+1)'(push_ok) - (PTR+1)'(pop_ok);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   if (!init) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (init)           state_nxt = ST_INIT;
        else if (violation) state_nxt = ST_ERROR;
        else if (push_ok)   state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (violation)           state_nxt = ST_ERROR;
        else if (occ_nxt == '0)  state_nxt = ST_IDLE;
      end
      ST_ERROR:  state_nxt = ST_ERROR;
      default:   state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    mem_push = push_ok;
    mem_pop  = pop_ok;
    idle     = (state == ST_IDLE);
  end

  // The ERROR state freezes the datapath simply because no request is ever accepted there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      error     <= 1'b0;
      th_af_reg <= TH_AF_RST;
      th_ae_reg <= TH_AE_RST;
    end else begin
      if (state == ST_INIT && init) begin
        th_af_reg <= th_af;
        th_ae_reg <= th_ae;
      end
      if (push_ok)   wr_ptr <= wr_ptr + PTR'(1);
      if (pop_ok)    rd_ptr <= rd_ptr + PTR'(1);
      occupancy <= occ_nxt;
      if (violation) error <= 1'b1;
    end
  end

endmodule
